// File: rtl/ahb2apb.sv
// AHB-Lite to APB bridge: one outstanding transfer at a time.
//
// An accepted AHB NONSEQ/SEQ transfer is latched, converted into an APB
// SETUP/ACCESS sequence, and completed back on AHB with OKAY or a two-cycle
// ERROR. Transfers wider than a word are rejected without touching APB.
//
// Ports:
//   aclk, aresetn   clock and synchronous active-low reset
//   ahb_*           AHB-Lite slave side (address/control in, data/response out)
//   apb_*           APB requester side (paddr/psel/penable/pwrite/pwdata/pstrb out,
//                   prdata/pready/pslverr in)
// All outputs are registered.
module ahb2apb #(
  parameter int unsigned PADDR_W = 16
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [31:0]        ahb_haddr,
  input  logic [2:0]         ahb_hsize,
  input  logic [1:0]         ahb_htrans,
  input  logic [31:0]        ahb_hwdata,
  input  logic               ahb_hwrite,
  input  logic               ahb_hready,
  input  logic               ahb_hselx,
  output logic [31:0]        ahb_hrdata,
  output logic               ahb_hresp,
  output logic               ahb_hreadyout,
  output logic [PADDR_W-1:0] apb_paddr,
  output logic               apb_psel,
  output logic               apb_penable,
  output logic               apb_pwrite,
  output logic [31:0]        apb_pwdata,
  output logic [3:0]         apb_pstrb,
  input  logic [31:0]        apb_prdata,
  input  logic               apb_pready,
  input  logic               apb_pslverr
);

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StSetup,
    StAccess,
    StDone,
    StErr1,
    StErr2
  } state_e;

  state_e               state;
  logic [PADDR_W-1:0]   addr_q;
  logic                 write_q;
  logic [1:0]           size_q;
  logic                 accept;
  logic [3:0]           strb;

  // Upper address bits are outside the APB window and intentionally dropped.
  logic unused_haddr;
  assign unused_haddr = ^ahb_haddr[31:PADDR_W];

  // New transfers are only taken when the bridge is not busy with one.
  assign accept = ahb_hselx & ahb_hready & ahb_htrans[1] &
                  ((state == StIdle) | (state == StDone) | (state == StErr2));

  // Byte lanes from the latched size and low address bits; reads strobe nothing.
  always_comb begin
    strb = 4'b0000;
    if (write_q) begin
      case (size_q)
        2'd0:    strb = 4'b0001 << addr_q[1:0];
        2'd1:    strb = 4'b0011 << {addr_q[1], 1'b0};
        default: strb = 4'b1111;
      endcase
    end
  end

  // Outputs are registered alongside the state so each one already reflects
  // the state being entered.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= StIdle;
      addr_q        <= '0;
      write_q       <= 1'b0;
      size_q        <= 2'd0;
      ahb_hrdata    <= 32'h0;
      ahb_hresp     <= 1'b0;
      ahb_hreadyout <= 1'b1;
      apb_paddr     <= '0;
      apb_psel      <= 1'b0;
      apb_penable   <= 1'b0;
      apb_pwrite    <= 1'b0;
      apb_pwdata    <= 32'h0;
      apb_pstrb     <= 4'b0000;
    end else begin
      case (state)
        StIdle, StDone, StErr2: begin
          if (accept) begin
            addr_q        <= ahb_haddr[PADDR_W-1:0];
            write_q       <= ahb_hwrite;
            size_q        <= ahb_hsize[1:0];
            ahb_hreadyout <= 1'b0;
            if (ahb_hsize > 3'd2) begin
              state     <= StErr1;
              ahb_hresp <= 1'b1;
            end else begin
              state     <= StLatch;
              ahb_hresp <= 1'b0;
            end
          end else begin
            state         <= StIdle;
            ahb_hreadyout <= 1'b1;
            ahb_hresp     <= 1'b0;
          end
        end

        // hwdata is valid in this cycle (AHB data phase); launch the APB
        // address/control so they are stable from SETUP onward.
        StLatch: begin
          state       <= StSetup;
          apb_psel    <= 1'b1;
          apb_penable <= 1'b0;
          apb_paddr   <= addr_q;
          apb_pwrite  <= write_q;
          apb_pstrb   <= strb;
          if (write_q) begin
            apb_pwdata <= ahb_hwdata;
          end
        end

        StSetup: begin
          state       <= StAccess;
          apb_penable <= 1'b1;
        end

        StAccess: begin
          if (apb_pready) begin
            apb_psel    <= 1'b0;
            apb_penable <= 1'b0;
            if (!apb_pwrite) begin
              ahb_hrdata <= apb_prdata;
            end
            if (apb_pslverr) begin
              state     <= StErr1;
              ahb_hresp <= 1'b1;
            end else begin
              state         <= StDone;
              ahb_hreadyout <= 1'b1;
            end
          end
        end

        // Second cycle of the AHB ERROR response.
        StErr1: begin
          state         <= StErr2;
          ahb_hresp     <= 1'b1;
          ahb_hreadyout <= 1'b1;
        end

        default: begin
          state         <= StIdle;
          ahb_hresp     <= 1'b0;
          ahb_hreadyout <= 1'b1;
          apb_psel      <= 1'b0;
          apb_penable   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb2apb.sv
module tb_ahb2apb;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] ahb_haddr;
  logic [2:0]  ahb_hsize;
  logic [1:0]  ahb_htrans;
  logic [31:0] ahb_hwdata;
  logic        ahb_hwrite;
  logic        ahb_hready;
  logic        ahb_hselx;
  logic [31:0] ahb_hrdata;
  logic        ahb_hresp;
  logic        ahb_hreadyout;
  logic [15:0] apb_paddr;
  logic        apb_psel;
  logic        apb_penable;
  logic        apb_pwrite;
  logic [31:0] apb_pwdata;
  logic [3:0]  apb_pstrb;
  logic [31:0] apb_prdata;
  logic        apb_pready;
  logic        apb_pslverr;

  always #5 aclk = ~aclk;

  ahb2apb #(.PADDR_W(16)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .ahb_haddr     (ahb_haddr),
    .ahb_hsize     (ahb_hsize),
    .ahb_htrans    (ahb_htrans),
    .ahb_hwdata    (ahb_hwdata),
    .ahb_hwrite    (ahb_hwrite),
    .ahb_hready    (ahb_hready),
    .ahb_hselx     (ahb_hselx),
    .ahb_hrdata    (ahb_hrdata),
    .ahb_hresp     (ahb_hresp),
    .ahb_hreadyout (ahb_hreadyout),
    .apb_paddr     (apb_paddr),
    .apb_psel      (apb_psel),
    .apb_penable   (apb_penable),
    .apb_pwrite    (apb_pwrite),
    .apb_pwdata    (apb_pwdata),
    .apb_pstrb     (apb_pstrb),
    .apb_prdata    (apb_prdata),
    .apb_pready    (apb_pready),
    .apb_pslverr   (apb_pslverr)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          waits;
    logic        slverr;
    logic [31:0] prdata;
    logic [3:0]  strb;
  } vec_t;

  typedef struct {
    logic [15:0] paddr;
    logic [3:0]  strb;
    logic [31:0] pwdata;
    logic        pwrite;
  } apb_t;

  apb_t        sb[$];
  int          nchk = 0;
  int          nerr = 0;
  logic [31:0] exp_hrdata;
  logic [31:0] exp_pwdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every APB SETUP cycle must match the next queued expectation.
  always @(negedge aclk) begin
    if (aresetn === 1'b1 && apb_psel === 1'b1 && apb_penable === 1'b0) begin
      if (sb.size() == 0) begin
        chk("apb_unexpected_setup", 32'd1, 32'd0);
      end else begin
        apb_t e;
        e = sb.pop_front();
        chk("setup_paddr", {16'h0, apb_paddr}, {16'h0, e.paddr});
        chk("setup_pstrb", {28'h0, apb_pstrb}, {28'h0, e.strb});
        chk("setup_pwdata", apb_pwdata, e.pwdata);
        chk("setup_pwrite", {31'h0, apb_pwrite}, {31'h0, e.pwrite});
      end
    end
  end

  task automatic idle_bus();
    ahb_htrans = 2'b00;
    ahb_hselx  = 1'b0;
    ahb_hwrite = 1'b0;
    ahb_hsize  = 3'd0;
    ahb_haddr  = 32'h0;
  endtask

  task automatic drive_accept(input logic w, input logic [31:0] a, input logic [2:0] s);
    ahb_haddr  = a;
    ahb_hsize  = s;
    ahb_hwrite = w;
    ahb_htrans = 2'b10;
    ahb_hselx  = 1'b1;
    ahb_hready = 1'b1;
  endtask

  task automatic push_exp(input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] st);
    apb_t e;
    if (w) exp_pwdata = wd;
    e.paddr  = a[15:0];
    e.strb   = st;
    e.pwdata = exp_pwdata;
    e.pwrite = w;
    sb.push_back(e);
  endtask

  // One complete transfer starting from IDLE, just after a rising edge.
  task automatic do_xfer(input vec_t v, input int idx);
    int   cyc;
    int   done_cyc;
    int   pen;
    int   wcnt;
    int   exp_cyc;
    logic prev_hresp;
    logic size_err;
    size_err = (v.size > 3'd2);
    cyc = 0; done_cyc = -1; pen = 0; wcnt = 0; prev_hresp = 1'b0;
    drive_accept(v.write, v.addr, v.size);
    apb_pready  = 1'b0;
    apb_pslverr = 1'b0;
    apb_prdata  = v.prdata;
    if (!size_err) push_exp(v.write, v.addr, v.wdata, v.strb);
    while (done_cyc < 0 && cyc < 40) begin
      @(negedge aclk);
      if (apb_psel && apb_penable) begin
        pen++;
        apb_pready  = (wcnt == v.waits);
        apb_pslverr = apb_pready & v.slverr;
        wcnt++;
      end else begin
        apb_pready  = 1'b0;
        apb_pslverr = 1'b0;
      end
      if (cyc > 0 && ahb_hreadyout) begin
        done_cyc = cyc;
        chk($sformatf("v%0d_hresp", idx), {31'h0, ahb_hresp},
            {31'h0, size_err | v.slverr});
        chk($sformatf("v%0d_prev_hresp", idx), {31'h0, prev_hresp},
            {31'h0, size_err | v.slverr});
        if (!v.write && !size_err) exp_hrdata = v.prdata;
        chk($sformatf("v%0d_hrdata", idx), ahb_hrdata, exp_hrdata);
      end
      prev_hresp = ahb_hresp;
      @(posedge aclk); #1;
      if (cyc == 0) begin
        idle_bus();
        ahb_hwdata = v.wdata;
      end
      cyc++;
    end
    if (size_err) exp_cyc = 2;
    else exp_cyc = 4 + v.waits + (v.slverr ? 1 : 0);
    chk($sformatf("v%0d_done_cycle", idx), done_cyc, exp_cyc);
    chk($sformatf("v%0d_penable_cycles", idx), pen, size_err ? 0 : v.waits + 1);
  endtask

  vec_t vecs[10];
  logic exp_psel[9];
  logic exp_pen[9];
  logic exp_hrdy[9];

  initial begin
    vecs[0] = '{1'b1, 32'h0000_1006, 3'd1, 32'hABCD_0000, 0, 1'b0, 32'h0, 4'b1100};
    vecs[1] = '{1'b0, 32'h0000_0010, 3'd2, 32'h0,         3, 1'b0, 32'h1234_5678, 4'b0000};
    vecs[2] = '{1'b1, 32'h0000_2003, 3'd0, 32'h1122_3344, 1, 1'b0, 32'h0, 4'b1000};
    vecs[3] = '{1'b1, 32'h0000_0004, 3'd2, 32'hCAFE_BABE, 0, 1'b0, 32'h0, 4'b1111};
    vecs[4] = '{1'b1, 32'h0000_3000, 3'd1, 32'h55AA_55AA, 0, 1'b0, 32'h0, 4'b0011};
    vecs[5] = '{1'b1, 32'h0000_0008, 3'd2, 32'hDEAD_BEEF, 0, 1'b1, 32'h0, 4'b1111};
    vecs[6] = '{1'b0, 32'h0000_0020, 3'd2, 32'h0,         1, 1'b1, 32'h0BAD_F00D, 4'b0000};
    vecs[7] = '{1'b1, 32'h0000_0040, 3'd3, 32'h9999_9999, 0, 1'b0, 32'h0, 4'b0000};
    vecs[8] = '{1'b0, 32'h1234_5FFC, 3'd0, 32'h0,         2, 1'b0, 32'hA5A5_A5A5, 4'b0000};
    vecs[9] = '{1'b1, 32'h0000_0001, 3'd0, 32'h0000_00FF, 0, 1'b0, 32'h0, 4'b0010};
    exp_psel = '{0, 0, 1, 1, 0, 0, 1, 1, 0};
    exp_pen  = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
    exp_hrdy = '{1, 0, 0, 0, 1, 0, 0, 0, 1};

    aresetn     = 1'b0;
    ahb_hready  = 1'b1;
    ahb_hwdata  = 32'h0;
    apb_prdata  = 32'h0;
    apb_pready  = 1'b0;
    apb_pslverr = 1'b0;
    idle_bus();
    exp_hrdata = 32'h0;
    exp_pwdata = 32'h0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_hreadyout", {31'h0, ahb_hreadyout}, 32'd1);
    chk("rst_hresp", {31'h0, ahb_hresp}, 32'd0);
    chk("rst_hrdata", ahb_hrdata, 32'h0);
    chk("rst_psel", {31'h0, apb_psel}, 32'd0);
    chk("rst_penable", {31'h0, apb_penable}, 32'd0);
    chk("rst_paddr", {16'h0, apb_paddr}, 32'h0);
    chk("rst_pwrite", {31'h0, apb_pwrite}, 32'd0);
    chk("rst_pwdata", apb_pwdata, 32'h0);
    chk("rst_pstrb", {28'h0, apb_pstrb}, 32'h0);
    @(posedge aclk); #1;
    aresetn = 1'b1;

    // IDLE, BUSY and unselected NONSEQ must all be ignored.
    for (int i = 0; i < 3; i++) begin
      ahb_htrans = (i == 0) ? 2'b00 : (i == 1) ? 2'b01 : 2'b10;
      ahb_hselx  = (i != 2);
      ahb_hwrite = 1'b1;
      ahb_haddr  = 32'h0000_0100;
      ahb_hsize  = 3'd2;
      @(posedge aclk); #1;
      @(negedge aclk);
      chk($sformatf("ign%0d_hreadyout", i), {31'h0, ahb_hreadyout}, 32'd1);
      chk($sformatf("ign%0d_hresp", i), {31'h0, ahb_hresp}, 32'd0);
      chk($sformatf("ign%0d_psel", i), {31'h0, apb_psel}, 32'd0);
      @(posedge aclk); #1;
    end
    idle_bus();
    @(posedge aclk); #1;

    for (int i = 0; i < 10; i++) begin
      do_xfer(vecs[i], i);
      @(posedge aclk); #1;
    end

    // Back-to-back: read, then a write accepted in the read's DONE cycle.
    apb_pready  = 1'b1;
    apb_pslverr = 1'b0;
    apb_prdata  = 32'h7777_8888;
    for (int c = 0; c < 9; c++) begin
      if (c == 0) begin
        drive_accept(1'b0, 32'h0000_0030, 3'd2);
        push_exp(1'b0, 32'h0000_0030, 32'h0, 4'b0000);
      end else if (c == 4) begin
        drive_accept(1'b1, 32'h0000_0034, 3'd2);
        push_exp(1'b1, 32'h0000_0034, 32'h0BB0_0CC0, 4'b1111);
      end else if (c == 1 || c == 5) begin
        idle_bus();
        ahb_hwdata = 32'h0BB0_0CC0;
      end
      @(negedge aclk);
      chk($sformatf("b2b_c%0d_psel", c), {31'h0, apb_psel}, {31'h0, exp_psel[c]});
      chk($sformatf("b2b_c%0d_penable", c), {31'h0, apb_penable}, {31'h0, exp_pen[c]});
      chk($sformatf("b2b_c%0d_hreadyout", c), {31'h0, ahb_hreadyout}, {31'h0, exp_hrdy[c]});
      if (c == 4 || c == 8) chk($sformatf("b2b_c%0d_hrdata", c), ahb_hrdata, 32'h7777_8888);
      @(posedge aclk); #1;
    end
    exp_hrdata = 32'h7777_8888;
    idle_bus();
    apb_pready = 1'b0;
    @(posedge aclk); #1;

    // Reset while stalled in ACCESS abandons the transfer.
    drive_accept(1'b0, 32'h0000_0050, 3'd2);
    push_exp(1'b0, 32'h0000_0050, 32'h0, 4'b0000);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) idle_bus();
      if (c == 4) aresetn = 1'b0;
      @(negedge aclk);
      if (c == 4) chk("rst_mid_in_access", {31'h0, apb_psel & apb_penable}, 32'd1);
      @(posedge aclk); #1;
    end
    @(negedge aclk);
    chk("rst_mid_psel", {31'h0, apb_psel}, 32'd0);
    chk("rst_mid_penable", {31'h0, apb_penable}, 32'd0);
    chk("rst_mid_hreadyout", {31'h0, ahb_hreadyout}, 32'd1);
    chk("rst_mid_hrdata", ahb_hrdata, 32'h0);
    chk("rst_mid_paddr", {16'h0, apb_paddr}, 32'h0);
    @(posedge aclk); #1;
    aresetn    = 1'b1;
    exp_hrdata = 32'h0;
    exp_pwdata = 32'h0;
    begin
      vec_t v;
      v = '{1'b0, 32'h0000_0060, 3'd2, 32'h0, 0, 1'b0, 32'h600D_D00D, 4'b0000};
      do_xfer(v, 10);
    end
    @(posedge aclk); #1;
    chk("sb_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/ahb2apb.md
AHB2APB -- requirements
Module: ahb2apb

Interface
REQ-001 SHALL have parameter: PADDR_W, 16, APB address width (haddr[PADDR_W-1:0] forwarded).
REQ-002 SHALL have ports:
- aclk  in  1  clock, all state on rising edge
- aresetn  in  1  reset, synchronous, active-low
- ahb_haddr  in  32  AHB address
- ahb_hsize  in  3  transfer size
- ahb_htrans  in  2  transfer type
- ahb_hwdata  in  32  write data (data phase)
- ahb_hwrite  in  1  1=write
- ahb_hready  in  1  bus ready
- ahb_hselx  in  1  slave select
- ahb_hrdata  out  32  read data
- ahb_hresp  out  1  1=ERROR
- ahb_hreadyout  out  1  slave ready
- apb_paddr  out  PADDR_W  APB address
- apb_psel  out  1  select
- apb_penable  out  1  enable
- apb_pwrite  out  1  direction
- apb_pwdata  out  32  write data
- apb_pstrb  out  4  byte strobes
- apb_prdata  in  32  read data
- apb_pready  in  1  completer ready
- apb_pslverr  in  1  completer error
REQ-003 SHALL use reset aresetn, synchronous, active-low; clock aclk; all outputs registered.

Function
REQ-004 SHALL accept a transfer when ahb_hselx & ahb_hready & ahb_htrans[1] in states IDLE, DONE or ERR2 only; otherwise ignore AHB inputs.
REQ-005 SHALL latch on accept: haddr[PADDR_W-1:0], hwrite, hsize, haddr[1:0].
REQ-006 SHALL implement FSM IDLE, LATCH, SETUP, ACCESS, DONE, ERR1, ERR2.
REQ-007 Transitions: accept with hsize<=2 -> LATCH; accept with hsize>2 -> ERR1 (no APB access); LATCH -> SETUP; SETUP -> ACCESS; ACCESS & pready & !pslverr -> DONE; ACCESS & pready & pslverr -> ERR1; ACCESS & !pready -> ACCESS; ERR1 -> ERR2; DONE/ERR2 without accept -> IDLE.
REQ-008 LATCH SHALL capture ahb_hwdata into apb_pwdata (writes only); reads leave apb_pwdata unchanged.
REQ-009 SETUP: psel=1, penable=0; ACCESS: psel=1, penable=1; all other states psel=penable=0.
REQ-010 paddr, pwrite, pwdata, pstrb SHALL be stable from SETUP through last ACCESS cycle and hold afterwards until next LATCH.
REQ-011 pstrb for writes: size 0 -> 4'b0001<<addr[1:0]; size 1 -> 4'b0011<<(addr[1]*2); size 2 -> 4'b1111; reads -> 4'b0000.
REQ-012 hreadyout=1 in IDLE, DONE, ERR2; 0 in LATCH, SETUP, ACCESS, ERR1.
REQ-013 hresp=1 in ERR1 and ERR2 only (two-cycle AHB error response).
REQ-014 ahb_hrdata SHALL load apb_prdata on ACCESS & pready & !pwrite (including pslverr) and hold otherwise.
REQ-015 Latency: accept at cycle 0, SETUP cycle 2, first ACCESS cycle 3, hreadyout high cycle 4 with zero APB wait states; each pready-low cycle adds one.
REQ-016 Back-to-back: accept in DONE/ERR2 SHALL enter LATCH next cycle; psel SHALL deassert at least one cycle between transfers.
REQ-017 IDLE/BUSY htrans or hselx=0 SHALL give OKAY, hreadyout=1, no APB activity.
REQ-018 pslverr SHALL be sampled only when ACCESS & pready.

Reset
REQ-019 aresetn low SHALL force IDLE at next edge, any state, including mid-ACCESS (psel/penable drop, transfer abandoned).
REQ-020 Reset values: paddr 0, psel 0, penable 0, pwrite 0, pwdata 0, pstrb 0, hrdata 0, hresp 0, hreadyout 1.

Verification
REQ-021 Write haddr=0x0000_1006, hsize=1, hwdata=0xABCD_0000, pready=1 -> SETUP cycle 2 paddr=0x1006, pstrb=4'b1100, pwdata=0xABCD_0000; hreadyout=1 cycle 4, hresp=0.
REQ-022 Read haddr=0x0010, pready low 3 ACCESS cycles, prdata=0x1234_5678 -> penable high 4 cycles, hrdata=0x1234_5678 with hreadyout=1 at cycle 7.
REQ-023 Write with pslverr=1 at pready -> ERR1 (hresp=1,hreadyout=0) then ERR2 (hresp=1,hreadyout=1), then IDLE.
REQ-024 hsize=3'b011 accept -> psel never asserts; ERR1/ERR2 response.
REQ-025 Read at DONE immediately followed by write accept -> LATCH next cycle, psel low one cycle between the two APB transfers.
REQ-026 aresetn low during ACCESS with pready=0 -> next edge psel=0, penable=0, hreadyout=1; new transfer afterwards completes normally.
